instr_fetch: RTL and testbench

Instruction fetch stage of the single-cycle MIPS core, directly upstream of the main control decoder. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a req/ready handshake, and presents it with `opCode = instr[31:26]` to the decoder until the datapath retires it. On retire it selects the next PC from PC+4, the branch target or the jump target, using the decoder's `branch`/`jump` outputs and the ALU `zero` flag.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, req/ready fetch from instruction memory, next-PC select on retire.
// Optional stall counter enabled by defining FETCH_STALL_COUNT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [5:0]  o_op_code,
    output logic        o_instr_valid,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4_c,
    input  logic        i_retire,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_zero
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [15:0] o_stall_count
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_imem_req;
    logic              w_imem_req_nxt;
    logic              r_instr_valid;
    logic              w_instr_valid_nxt;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   w_instr_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_branch_off;
    logic [XLEN-1:0]   w_next_pc;

    // Next-PC select: jump beats taken branch beats sequential
    always_comb begin
        w_pc_plus4   = r_pc + XLEN'(4);
        w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_next_pc    = w_pc_plus4;
        if (i_jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (i_branch && i_zero) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (i_imem_ready) begin
                    w_instr_nxt = i_imem_data;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_retire) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Handshake flags are registered copies of the next state
        w_imem_req_nxt    = (w_state_nxt == ST_REQ);
        w_instr_valid_nxt = (w_state_nxt == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_pc          <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_pc          <= w_pc_nxt;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    localparam int unsigned SCW = 16;

    logic [SCW-1:0] r_stall_count;

    // Saturating count of REQ cycles without a memory response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if ((r_state == ST_REQ) && !i_imem_ready && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + SCW'(1);
        end
    end

    assign o_stall_count = r_stall_count;
`endif

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_op_code     = r_instr[XLEN-1:XLEN-OPW];
    assign o_instr_valid = r_instr_valid;
    assign o_pc_out      = r_pc;
    assign o_pc_plus4_c  = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed test-plan steps plus randomized fetches against a PC/stall reference model.
// A second instance reset to the top word of memory covers PC wrap-around.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        retire, branch, jump, zero;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc_out, pc_plus4;
    logic [5:0]  op_code;

    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_instr, w_pc_out, w_pc_plus4;
    logic [5:0]  w_op_code;

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count;
    logic [15:0] w_stall_count;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] m_pc;
    logic [15:0] m_stall;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ready (imem_ready),
        .i_imem_data  (imem_data),
        .o_instr      (instr),
        .o_op_code    (op_code),
        .o_instr_valid(instr_valid),
        .o_pc_out     (pc_out),
        .o_pc_plus4_c (pc_plus4),
        .i_retire     (retire),
        .i_branch     (branch),
        .i_jump       (jump),
        .i_zero       (zero)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .o_stall_count(stall_count)
`endif
    );

    instr_fetch #(.RESET_PC(WRAP_PC)) dut_w (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_imem_req   (w_imem_req),
        .o_imem_addr  (w_imem_addr),
        .i_imem_ready (imem_ready),
        .i_imem_data  (imem_data),
        .o_instr      (w_instr),
        .o_op_code    (w_op_code),
        .o_instr_valid(w_instr_valid),
        .o_pc_out     (w_pc_out),
        .o_pc_plus4_c (w_pc_plus4),
        .i_retire     (retire),
        .i_branch     (branch),
        .i_jump       (jump),
        .i_zero       (zero)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .o_stall_count(w_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural next-PC rule written as plain address arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic br, input logic jp, input logic z);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
        if (br && z) return seq + 32'($signed(ins[15:0])) * 32'd4;
        return seq;
    endfunction

    task automatic chk_stall();
`ifdef FETCH_STALL_COUNT_EN
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    endtask

    // One instruction: entered at a negedge with the DUT requesting; leaves at the negedge after retire
    task automatic fetch(input int waits, input logic [31:0] data, input int hold,
                         input logic br, input logic jp, input logic z);
        logic [31:0] exp_next;
        chk("req_start", 32'(imem_req), 32'd1);
        chk("addr_start", imem_addr, m_pc);
        chk("valid_start", 32'(instr_valid), 32'd0);
        for (int k = 0; k < waits; k++) begin
            imem_ready = 1'b0;
            imem_data  = $urandom;
            retire     = (k == 0) ? 1'b1 : 1'($urandom);
            branch     = 1'($urandom);
            jump       = 1'($urandom);
            zero       = 1'($urandom);
            @(negedge clk);
            if (m_stall != 16'hFFFF) m_stall++;
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_data  = data;
        retire     = 1'($urandom);
        @(negedge clk);
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_instr", instr, data);
        chk("hold_opcode", 32'(op_code), 32'(data[31:26]));
        chk("hold_pc", pc_out, m_pc);
        chk("hold_plus4", pc_plus4, m_pc + 32'd4);
        for (int k = 0; k < hold; k++) begin
            imem_ready = 1'($urandom);
            imem_data  = $urandom;
            retire     = 1'b0;
            @(negedge clk);
            chk("held_instr", instr, data);
            chk("held_valid", 32'(instr_valid), 32'd1);
            chk("held_pc", pc_out, m_pc);
        end
        imem_ready = 1'($urandom);
        imem_data  = $urandom;
        retire     = 1'b1;
        branch     = br;
        jump       = jp;
        zero       = z;
        exp_next   = model_next(m_pc, data, br, jp, z);
        @(negedge clk);
        retire     = 1'b0;
        imem_ready = 1'b0;
        m_pc       = exp_next;
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_valid", 32'(instr_valid), 32'd0);
        chk("next_addr", imem_addr, m_pc);
        chk_stall();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", 32'(op_code), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        imem_ready = 1'b1;
        imem_data  = $urandom;
        retire     = 1'b1;
        repeat (2) @(negedge clk);
        imem_ready = 1'b0;
        retire     = 1'b0;
        rst_n      = 1'b1;
        m_pc       = RST_PC;
        m_stall    = '0;
        #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        chk_stall();
        @(negedge clk);
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, RST_PC);
        chk("rel_valid", 32'(instr_valid), 32'd0);
        chk("w_rel_addr", w_imem_addr, WRAP_PC);
    endtask

    initial begin
        logic [31:0] d;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_data  = '0;
        retire     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        @(negedge clk);
        do_reset();

        fetch(0, 32'h2008_0005, 0, 1'b0, 1'b0, 1'b0);
        chk("seq_addr", imem_addr, 32'h0040_0004);
        chk("wrap_addr", w_imem_addr, 32'h0000_0000);
        chk("wrap_req", 32'(w_imem_req), 32'd1);
        fetch(0, 32'h0000_0020, 1, 1'b0, 1'b0, 1'b0);
        chk("seq2_addr", imem_addr, 32'h0040_0008);
        fetch(0, 32'h1000_FFFF, 0, 1'b1, 1'b0, 1'b1);
        chk("br_taken_addr", imem_addr, 32'h0040_0008);
        fetch(0, 32'h1000_FFFF, 0, 1'b1, 1'b0, 1'b0);
        chk("br_not_taken_addr", imem_addr, 32'h0040_000C);
        fetch(0, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0);
        fetch(0, 32'h0810_0010, 2, 1'b1, 1'b1, 1'b1);
        chk("jump_addr", imem_addr, 32'h0040_0040);
        fetch(3, 32'h0123_4567, 0, 1'b0, 1'b0, 1'b0);
        chk("after_wait_addr", imem_addr, 32'h0040_0044);
`ifdef FETCH_STALL_COUNT_EN
        chk("stall_three", 32'(stall_count), 32'd3);
`endif

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0:       d = {6'b000010, 26'($urandom)};
                1:       d = {6'b000100, 10'($urandom), 16'($urandom)};
                default: d = $urandom;
            endcase
            fetch(int'($urandom_range(0, 3)), d, int'($urandom_range(0, 2)),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a request, with a late memory response
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreq_req", 32'(imem_req), 32'd0);
        chk("midreq_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        do_reset();
        fetch(1, 32'h2008_0005, 0, 1'b0, 1'b0, 1'b0);
        chk("restart_addr", imem_addr, 32'h0040_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
